// File: rtl/dbuf_pkg.sv
// Shared constants and state type for the double-buffered frame store write scheduler.
package dbuf_pkg;

  localparam int HPIXELS    = 640;
  localparam int VPIXELS    = 480;
  localparam int BLOCK_SIZE = 20;
  localparam int HBLOCKS    = HPIXELS / BLOCK_SIZE;
  localparam int VBLOCKS    = VPIXELS / BLOCK_SIZE;
  localparam int CELLS      = HBLOCKS * VBLOCKS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } state_e;

endpackage

// File: rtl/dbuf_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: req_i[0] is requester A, req_i[1] is requester B.
// The pointer favours A after reset and flips to the opposite side after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic       ptr_q;   // 0: A favoured, 1: B favoured
  logic       ptr_d;
  logic [1:0] grant_s;

  // One-hot grant from the requests and the current pointer.
  always_comb begin
    grant_s = 2'b00;
    if (enable_i) begin
      case (req_i)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_q ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Next pointer: favour the side that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s[0]) begin
      ptr_d = 1'b1;
    end else if (grant_s[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/dbuf_write_sched.sv
// Write-side controller for the double-buffered cell frame store.
// Each frame: clear sweep of every cell with bg_color, then round-robin
// service of requesters A and B on the single write port.
// Optional macro DBUF_WRITE_STATS_EN adds writes_last_frame (in-range
// requester writes completed in the previous frame, saturating).
module dbuf_write_sched
  import dbuf_pkg::*;
#(
  parameter int HBLOCKS = dbuf_pkg::HBLOCKS,
  parameter int VBLOCKS = dbuf_pkg::VBLOCKS,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic [DATA_W-1:0] bg_color,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] pixel_data_out,
  output logic              frame_busy,
  output logic              frame_done,
`ifdef DBUF_WRITE_STATS_EN
  output logic [10:0]       writes_last_frame,
`endif
  output logic              overrun
);

  localparam int                CELLS_L   = HBLOCKS * VBLOCKS;
  localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W + 1)'(CELLS_L);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS_L - 1);

  state_e            state_q;
  logic              fs_cond_q;
  logic              fs_prev_q;
  logic              frame_start_s;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] bg_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] pixel_q;
  logic              done_q;
  logic              overrun_q;
  logic              arb_en_s;
  logic [1:0]        grant_s;
  logic              a_in_range_s;
  logic              b_in_range_s;

  assign frame_start_s = fs_cond_q & ~fs_prev_q;
  assign arb_en_s      = (state_q == SERVE) & ~frame_start_s;
  assign a_in_range_s  = ({1'b0, a_addr} < CELLS_W);
  assign b_in_range_s  = ({1'b0, b_addr} < CELLS_W);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (arb_en_s),
    .req_i    ({b_valid, a_valid}),
    .grant_o  (grant_s)
  );

  // Register the frame-origin condition so its rising edge marks frame start once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_cond_q <= 1'b0;
      fs_prev_q <= 1'b0;
    end else begin
      fs_cond_q <= (hc == 10'd0) && (vc == 10'd0);
      fs_prev_q <= fs_cond_q;
    end
  end

  // Sweep/serve state machine with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bg_q         <= '0;
      write_addr_q <= '0;
      pixel_q      <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_s) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            bg_q    <= bg_color;
          end
        end
        CLEAR: begin
          if (frame_start_s) begin
            // Frame arrived before the sweep finished: restart with the new colour.
            overrun_q <= 1'b1;
            cnt_q     <= '0;
            bg_q      <= bg_color;
          end else begin
            write_addr_q <= cnt_q;
            pixel_q      <= bg_q;
            cnt_q        <= cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= SERVE;
            end
          end
        end
        SERVE: begin
          if (frame_start_s) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            bg_q    <= bg_color;
          end else if (grant_s[0] && a_in_range_s) begin
            write_addr_q <= a_addr;
            pixel_q      <= a_data;
          end else if (grant_s[1] && b_in_range_s) begin
            write_addr_q <= b_addr;
            pixel_q      <= b_data;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DBUF_WRITE_STATS_EN
  localparam logic [10:0] STAT_MAX = 11'd2047;
  logic [10:0] stat_cnt_q;
  logic [10:0] wlf_q;
  logic        wr_ok_s;

  assign wr_ok_s = (grant_s[0] & a_in_range_s) | (grant_s[1] & b_in_range_s);

  // Count in-range requester writes; publish and clear the count at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= 11'd0;
      wlf_q      <= 11'd0;
    end else if (frame_start_s) begin
      wlf_q      <= stat_cnt_q;
      stat_cnt_q <= 11'd0;
    end else if (wr_ok_s && (stat_cnt_q != STAT_MAX)) begin
      stat_cnt_q <= stat_cnt_q + 11'd1;
    end
  end

  assign writes_last_frame = wlf_q;
`endif

  assign a_ready        = grant_s[0];
  assign b_ready        = grant_s[1];
  assign write_addr     = write_addr_q;
  assign pixel_data_out = pixel_q;
  assign frame_busy     = (state_q == CLEAR);
  assign frame_done     = done_q;
  assign overrun        = overrun_q;

endmodule
